// File: rtl/pwm_capture_if.sv
// pwm_capture_if: PWM input plus measurement results of pwm_capture.
// master = the capture block, slave = whoever drives PWM and consumes results.
`timescale 1ns/10ps
interface pwm_capture_if;
    logic        pwm_in;
    logic [7:0]  duty_cycle;
    logic [10:0] high_cycles;
    logic [10:0] period_cycles;
    logic        valid;
    logic        stuck;
    logic        err;

    modport master (
        input  pwm_in,
        output duty_cycle, high_cycles, period_cycles, valid, stuck, err
    );

    modport slave (
        output pwm_in,
        input  duty_cycle, high_cycles, period_cycles, valid, stuck, err
    );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: times high/low phases of a (possibly asynchronous) PWM input
// and reports period, high time and decoded 8-bit duty once per period.
// Optional feature macro: PWM_CAPTURE_PERIOD_CHECK_EN (rejects measurements
// whose period is outside NOMINAL_PERIOD +/- PERIOD_TOL).
`timescale 1ns/10ps
module pwm_capture #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT        = 2047,
    parameter int NOMINAL_PERIOD = 1024,
    parameter int PERIOD_TOL     = 4
) (
    input  logic         clk,
    input  logic         reset,
    pwm_capture_if.master bus
);
    // Edge detection is masked until the synchronizer pipeline holds real
    // samples, so a level that was already high at reset release is not
    // mistaken for a rising edge (the interrupted period is discarded).
    localparam int          PRIME = SYNC_STAGES + 2;
    localparam int          PW    = $clog2(PRIME + 1);
    localparam logic [10:0] TO    = 11'(TIMEOUT);
    localparam logic [10:0] SAT   = 11'h7FF;

    typedef enum logic [1:0] {ACQ, HIGH, LOW} state_t;

    // Elaboration-time sanity checks on the configuration.
    if (SYNC_STAGES < 2 || TIMEOUT < 2 || TIMEOUT > 2047 ||
        PERIOD_TOL < 0 || NOMINAL_PERIOD <= PERIOD_TOL) begin : g_bad_cfg
        $error("pwm_capture: illegal parameter combination");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_q;
    logic                   s_prev_q;
    logic [PW-1:0]          prime_q;
    logic                   primed;
    logic                   rise;
    logic                   fall;

    state_t      state_q;
    logic [10:0] hi_q;
    logic [10:0] lo_q;
    logic [10:0] idle_q;
    logic [7:0]  duty_q;
    logic [10:0] high_q;
    logic [10:0] period_q;
    logic        valid_q;
    logic        stuck_q;

    logic [10:0] hi_inc_d;
    logic [10:0] lo_inc_d;
    logic [11:0] sum_d;
    logic [10:0] period_d;
    logic [10:0] hm1_d;
    logic [7:0]  duty_d;
    logic [10:0] idle_d;
    logic        timeout_d;

    // Input synchronizer, level flop `s` and its delayed copy for edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            s_q      <= 1'b0;
            s_prev_q <= 1'b0;
            prime_q  <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
            s_q      <= sync_q[SYNC_STAGES-1];
            s_prev_q <= s_q;
            if (!primed) prime_q <= prime_q + 1'b1;
        end
    end

    assign primed = (prime_q == PW'(PRIME));
    assign rise   = primed &  s_q & ~s_prev_q;
    assign fall   = primed & ~s_q &  s_prev_q;

    // Saturating counters and the decode of a completed measurement.
    assign hi_inc_d = (hi_q == SAT) ? hi_q : hi_q + 11'd1;
    assign lo_inc_d = (lo_q == SAT) ? lo_q : lo_q + 11'd1;
    assign sum_d    = {1'b0, hi_q} + {1'b0, lo_q};
    assign period_d = sum_d[11] ? SAT : sum_d[10:0];
    assign hm1_d    = hi_q - 11'd1;
    assign duty_d   = hm1_d[10] ? 8'hFF : hm1_d[9:2];

    // Idle counter: cleared by any edge, parks at TIMEOUT so stuck fires once.
    assign idle_d    = (!primed || rise || fall) ? 11'd0 :
                       (idle_q == TO)            ? TO    : idle_q + 11'd1;
    assign timeout_d = primed && !rise && !fall && (idle_q == TO - 11'd1);

`ifdef PWM_CAPTURE_PERIOD_CHECK_EN
    logic err_q;
    int   diff_d;
    logic period_bad_d;

    assign diff_d       = int'(period_d) - NOMINAL_PERIOD;
    assign period_bad_d = (diff_d > PERIOD_TOL) || (diff_d < -PERIOD_TOL);
    assign bus.err      = err_q;
`else
    assign bus.err = 1'b0;
`endif

    // Measurement FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ACQ;
            hi_q     <= '0;
            lo_q     <= '0;
            idle_q   <= '0;
            duty_q   <= '0;
            high_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
`ifdef PWM_CAPTURE_PERIOD_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            idle_q  <= idle_d;
`ifdef PWM_CAPTURE_PERIOD_CHECK_EN
            err_q   <= 1'b0;
`endif
            if (timeout_d) begin
                stuck_q  <= 1'b1;
                valid_q  <= 1'b1;
                duty_q   <= s_q ? 8'hFF : 8'h00;
                high_q   <= '0;
                period_q <= '0;
                hi_q     <= '0;
                lo_q     <= '0;
                state_q  <= ACQ;
            end else begin
                case (state_q)
                    ACQ: begin
                        if (rise) begin
                            stuck_q <= 1'b0;
                            hi_q    <= 11'd1;
                            lo_q    <= '0;
                            state_q <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            lo_q    <= 11'd1;
                            state_q <= LOW;
                        end else begin
                            hi_q <= hi_inc_d;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            high_q   <= hi_q;
                            period_q <= period_d;
                            valid_q  <= 1'b1;
`ifdef PWM_CAPTURE_PERIOD_CHECK_EN
                            err_q    <= period_bad_d;
                            if (!period_bad_d) duty_q <= duty_d;
`else
                            duty_q   <= duty_d;
`endif
                            hi_q     <= 11'd1;
                            lo_q     <= '0;
                            state_q  <= HIGH;
                        end else begin
                            lo_q <= lo_inc_d;
                        end
                    end
                    default: state_q <= ACQ;
                endcase
            end
        end
    end

    assign bus.duty_cycle    = duty_q;
    assign bus.high_cycles   = high_q;
    assign bus.period_cycles = period_q;
    assign bus.valid         = valid_q;
    assign bus.stuck         = stuck_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed test of pwm_capture with hand-computed expectations.
`timescale 1ns/10ps
module tb_pwm_capture;
    localparam int TO = 2047;

    typedef struct {
        int          cyc;
        logic [7:0]  duty;
        logic [10:0] hi;
        logic [10:0] per;
        logic        stuck;
        logic        err;
    } rec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    rec_t q[$];

    pwm_capture_if bus();

    pwm_capture #(
        .SYNC_STAGES(2), .TIMEOUT(TO), .NOMINAL_PERIOD(1024), .PERIOD_TOL(4)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid pulse with the cycle it was seen in.
    always @(posedge clk) begin
        rec_t r;
        #1;
        if (bus.valid === 1'b1) begin
            r.cyc   = cyc;
            r.duty  = bus.duty_cycle;
            r.hi    = bus.high_cycles;
            r.per   = bus.period_cycles;
            r.stuck = bus.stuck;
            r.err   = bus.err;
            q.push_back(r);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_duty"},   32'(bus.duty_cycle),    0);
        chk({tag, "_high"},   32'(bus.high_cycles),   0);
        chk({tag, "_period"}, 32'(bus.period_cycles), 0);
        chk({tag, "_valid"},  32'(bus.valid),         0);
        chk({tag, "_stuck"},  32'(bus.stuck),         0);
        chk({tag, "_err"},    32'(bus.err),           0);
    endtask

    // One generator-style period: high for `hi` cycles starting with a rise.
    task automatic drive_period(input int hi, input int per, output int rc);
        rc = 0;
        for (int c = 0; c < per; c++) begin
            bus.pwm_in = (c < hi);
            if (c == 0) rc = cyc;
            tick();
        end
    endtask

    initial begin
        int hs[8] = '{513, 513, 513, 1, 5, 1017, 1021, 513};
        int ds[8] = '{128, 128, 128, 0, 1, 254, 255, 128};
        int rise[9];
        int rc;
        int nq;

        // Reset state
        bus.pwm_in = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        chk_zero("reset");
        reset = 1'b0;
        repeat (5) tick();
        chk("reset_no_valid", 32'(q.size()), 0);

        // Duty 128 x3, then sweep 0/1/254/255, then 128, then hold high
        for (int i = 0; i < 8; i++) begin
            drive_period(hs[i], 1024, rc);
            rise[i] = rc;
        end
        bus.pwm_in = 1'b1;
        rise[8] = cyc;
        repeat (TO + 20) tick();
        chk("rec_count", 32'(q.size()), 9);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rec%0d_duty", i),  32'(q[i].duty),  ds[i]);
            chk($sformatf("rec%0d_high", i),  32'(q[i].hi),    hs[i]);
            chk($sformatf("rec%0d_per", i),   32'(q[i].per),   1024);
            chk($sformatf("rec%0d_err", i),   32'(q[i].err),   0);
            chk($sformatf("rec%0d_stuck", i), 32'(q[i].stuck), 0);
            chk($sformatf("rec%0d_cyc", i),   32'(q[i].cyc),   rise[i+1] + 4);
        end
        chk("stuck_flag",  32'(q[8].stuck), 1);
        chk("stuck_duty",  32'(q[8].duty),  255);
        chk("stuck_high",  32'(q[8].hi),    0);
        chk("stuck_per",   32'(q[8].per),   0);
        chk("stuck_cyc",   32'(q[8].cyc),   q[7].cyc + TO);
        chk("stuck_level", 32'(bus.stuck),  1);

        // Falling edge keeps stuck; rising edge clears it without a valid
        bus.pwm_in = 1'b0;
        repeat (100) tick();
        chk("stuck_after_fall", 32'(bus.stuck), 1);
        drive_period(513, 1024, rc);
        chk("resume_no_valid", 32'(q.size()), 9);
        chk("resume_stuck_clr", 32'(bus.stuck), 0);
        drive_period(513, 1024, rc);
        chk("resume_count", 32'(q.size()), 10);
        chk("resume_cyc",   32'(q[9].cyc),  rc + 4);
        chk("resume_duty",  32'(q[9].duty), 128);

        // Reset for one cycle in the middle of a high phase
        bus.pwm_in = 1'b1;
        repeat (200) tick();
        reset = 1'b1;
        tick();
        chk_zero("midreset");
        reset = 1'b0;
        repeat (313) tick();
        bus.pwm_in = 1'b0;
        repeat (511) tick();
        drive_period(513, 1024, rc);
        chk("post_reset_no_valid", 32'(q.size()), 11);
        drive_period(401, 900, rc);
        chk("post_reset_count", 32'(q.size()), 12);
        chk("post_reset_duty",  32'(q[11].duty), 128);
        chk("post_reset_high",  32'(q[11].hi),   513);
        chk("post_reset_per",   32'(q[11].per),  1024);

        // Off-nominal period 900 / high 401
        bus.pwm_in = 1'b1;
        repeat (10) tick();
        chk("p900_count", 32'(q.size()), 13);
        chk("p900_high",  32'(q[12].hi),  401);
        chk("p900_per",   32'(q[12].per), 900);
`ifdef PWM_CAPTURE_PERIOD_CHECK_EN
        chk("p900_err",   32'(q[12].err),  1);
        chk("p900_duty",  32'(q[12].duty), 128);
`else
        chk("p900_err",   32'(q[12].err),  0);
        chk("p900_duty",  32'(q[12].duty), 100);
`endif

        // Asynchronous source, duty 64, starting mid-high after a reset
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        nq = q.size();
        #1003.7;
        bus.pwm_in = 1'b0;
        #7670.0;
        for (int k = 0; k < 6; k++) begin
            bus.pwm_in = 1'b1;
            #2571.37;
            if (k == 0) chk("async_no_partial", 32'(q.size()), nq);
            bus.pwm_in = 1'b0;
            #7670.0;
        end
        tick();
        chk("async_count", 32'(q.size()), nq + 5);
        for (int i = nq; i < nq + 5 && i < q.size(); i++) begin
            chk($sformatf("async%0d_duty_ok", i), 32'(q[i].duty >= 8'd63 && q[i].duty <= 8'd65), 1);
            chk($sformatf("async%0d_high_ok", i), 32'(q[i].hi >= 11'd256 && q[i].hi <= 11'd259), 1);
            chk($sformatf("async%0d_err", i),     32'(q[i].err), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and recovers the 8-bit duty-cycle code that produced it, the receive-side counterpart of the controller's PWM generator. The generator runs a free 10-bit counter (period 1024 clk) and drives high while counter ≤ duty·4, giving a high time of 4·duty+1 cycles. This block times high and low phases of a possibly asynchronous input and reports period, high time and decoded duty once per PWM period. It sits on the feedback path so the P-controller can close a loop on, or self-check, a PWM signal.

## Interface
- SYNC_STAGES, 2: flip-flops in the input synchronizer (≥2).
- TIMEOUT, 2047: cycles without an edge before the stuck condition is declared (≤2047).
- NOMINAL_PERIOD, 1024: expected period in clk cycles; used only with the period check.
- PERIOD_TOL, 4: allowed ± deviation from NOMINAL_PERIOD; used only with the period check.
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- pwm_in  input  1  PWM input, may be asynchronous to clk.
- duty_cycle  output  8  decoded duty code, held between updates.
- high_cycles  output  11  high time of the last measured period, in clk cycles.
- period_cycles  output  11  rising-to-rising interval of the last period, in clk cycles.
- valid  output  1  one-cycle pulse when the outputs update.
- stuck  output  1  level; input has shown no edge for TIMEOUT cycles.
- err  output  1  one-cycle pulse alongside valid when the measurement is rejected.

## Operation
- pwm_in passes through SYNC_STAGES flops, then a further flop for edge detection. All logic uses the synchronized level `s` only.
- FSM states: ACQ, HIGH, LOW.
  - ACQ: wait for a rising edge of `s`, then go to HIGH with hi_cnt=1 and lo_cnt=0. Partial periods seen before the first rising edge are discarded.
  - HIGH: hi_cnt++ while `s`=1. On a falling edge, go to LOW with lo_cnt=1.
  - LOW: lo_cnt++ while `s`=0. On a rising edge, complete the measurement and go to HIGH with hi_cnt=1, lo_cnt=0.
- Completing a measurement:
  - period_cycles = hi_cnt + lo_cnt and high_cycles = hi_cnt.
  - duty_cycle = min(255, (hi_cnt−1)>>2).
  - valid pulses.
- Counters are 11 bits and saturate at 2047, with no wrap. period_cycles also saturates at 2047.
- Timeout:
  - A separate idle counter resets on every edge of `s`.
  - When it reaches TIMEOUT, set stuck=1 and pulse valid.
  - duty_cycle becomes 255 if `s`=1, else 0. high_cycles and period_cycles become 0.
  - FSM returns to ACQ.
  - stuck clears on the next rising edge of `s`. The next valid comes only after a full period is measured.
- Reset:
  - State goes to ACQ and all counters to 0.
  - duty_cycle=0, high_cycles=0, period_cycles=0, valid=0, stuck=0, err=0.
  - Synchronizer flops reset to 0.
  - A reset asserted mid-period discards that period.

## Timing
- Reset is synchronous: it takes effect at the first clk edge where reset=1. Outputs are at reset values in the following cycle.
- For a clk-synchronous source whose rising edge is sampled high at clk edge k:
  - valid is high in the cycle after edge k+SYNC_STAGES+1.
  - Outputs change at that same edge.
- Counts are exact for a clk-synchronous source. For an asynchronous source each edge carries ±1 cycle uncertainty.
- Minimum resolvable phase is 1 cycle. The generator's duty 0 (high time 1) yields high_cycles=1 and duty_cycle=0.
- If a falling and rising edge fall within one synchronizer sample, the pulse is invisible and merges into the surrounding phase.
- Outputs are registered with no combinational path from pwm_in.

## Configuration
- Macro: PWM_CAPTURE_PERIOD_CHECK_EN.
- Defined:
  - A measurement with |period − NOMINAL_PERIOD| > PERIOD_TOL pulses err together with valid.
  - period_cycles and high_cycles update.
  - duty_cycle keeps its previous value.
- Undefined:
  - err is tied 0 and every measurement updates duty_cycle.
  - NOMINAL_PERIOD and PERIOD_TOL are unused.

## Test plan
- Generator-style input with duty 128 (high 513, low 511, synchronous) → after the first full period: valid once per 1024 cycles, high_cycles=513, period_cycles=1024, duty_cycle=128.
- Sweep duty 0, 1, 254, 255 (high 1, 5, 1017, 1021 of 1024) → duty_cycle 0, 1, 254, 255.
- Hold pwm_in high after a valid period → valid with stuck=1 and duty_cycle=255 exactly TIMEOUT cycles after the last edge. Resume PWM → stuck clears on the rising edge, and the next valid comes one period later.
- Assert reset for 1 cycle mid-high-phase → all outputs 0 the next cycle; no valid until one complete rise-to-rise period after reset.
- With PWM_CAPTURE_PERIOD_CHECK_EN, period 900 with high 401 → valid and err together, period_cycles=900, duty_cycle unchanged. Without the macro → err=0 and duty_cycle=100.
- Asynchronous source (clk/pwm ratio 1.37) with duty 64 → every duty_cycle within 64±1, and no valid during the first partial period.
